nrisc_pc_sequencer: RTL and testbench

- Program-counter sequencer for the 8-bit nRisc core.
- Consumes the branch target produced by the branch-address adder (PC + offset) and generates the fetch address stream.
- Also supplies `pc_plus1` back to the adder.
- Handles sequential increment, taken branches, absolute jumps, stall, halt/resume and a one-cycle redirect bubble.

---
 rtl/nrisc_pc_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_nrisc_pc_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/nrisc_pc_sequencer.sv
// nrisc_pc_sequencer: program-counter sequencer for the 8-bit nRisc core.
// Generates the fetch address stream from sequential increment, taken
// branches and absolute jumps. It also handles stall, halt/resume and a
// one-cycle bubble after every redirect.
// Optional feature: define NRISC_RAS_EN to build a RAS_DEPTH-entry
// return-address stack. With the stack, call_en and ret_en act as redirects.
// Without it, call_en and ret_en are ignored and ras_err is tied low.
module nrisc_pc_sequencer #(
  parameter logic [7:0] RESET_PC  = 8'h00,
  parameter int         RAS_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       stall_i,
  input  logic       branch_en_i,
  input  logic [7:0] branch_target_i,
  input  logic       jump_en_i,
  input  logic [7:0] jump_addr_i,
  input  logic       call_en_i,
  input  logic       ret_en_i,
  input  logic       halt_req_i,
  input  logic       resume_i,
  output logic [7:0] pc_o,
  output logic [7:0] pc_plus1_o,
  output logic       fetch_valid_o,
  output logic       flush_o,
  output logic       pc_wrap_o,
  output logic       halted_o,
  output logic       ras_err_o
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic       flush_q, flush_d;
  logic       wrap_q, wrap_d;
  logic [7:0] pc_inc;

  // Return-stack hooks, driven by the optional stack (or constants without it)
  logic       ret_sel;
  logic       call_sel;
  logic [7:0] pop_addr;
  logic       push_req;
  logic       pop_req;

  assign pc_inc = pc_q + 8'd1;

  assign pc_o          = pc_q;
  assign pc_plus1_o    = pc_inc;
  assign fetch_valid_o = (state_q == ST_RUN) && !stall_i;
  assign flush_o       = flush_q;
  assign pc_wrap_o     = wrap_q;
  assign halted_o      = (state_q == ST_HALT);

  // Control state, pc and the one-cycle pulse registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state and pc selection; pulses default low so each lasts one cycle
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flush_d  = 1'b0;
    wrap_d   = 1'b0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        if (halt_req_i) begin
          state_d = ST_HALT;
        end else if (stall_i) begin
          state_d = ST_RUN;
        end else if (ret_sel) begin
          pop_req = 1'b1;
          pc_d    = pop_addr;
          state_d = ST_BUBBLE;
          flush_d = 1'b1;
        end else if (call_sel) begin
          push_req = 1'b1;
          pc_d     = jump_addr_i;
          state_d  = ST_BUBBLE;
          flush_d  = 1'b1;
        end else if (jump_en_i) begin
          pc_d    = jump_addr_i;
          state_d = ST_BUBBLE;
          flush_d = 1'b1;
        end else if (branch_en_i) begin
          pc_d    = branch_target_i;
          state_d = ST_BUBBLE;
          flush_d = 1'b1;
        end else begin
          pc_d   = pc_inc;
          wrap_d = (pc_q == 8'hFF);
        end
      end
      ST_BUBBLE: begin
        if (halt_req_i) begin
          state_d = ST_HALT;
        end else if (!stall_i) begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (resume_i) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

`ifdef NRISC_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [7:0]       ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [PTR_W-1:0] top_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ras_empty;
  logic             ras_full;

  // sp_q is the next free slot; the stack is circular so a push onto a full
  // stack lands on the oldest entry.
  assign top_idx   = (sp_q == '0) ? PTR_W'(RAS_DEPTH - 1) : sp_q - PTR_W'(1);
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ret_sel   = ret_en_i;
  assign call_sel  = call_en_i;
  assign pop_addr  = ras_empty ? RESET_PC : ras_mem[top_idx];
  assign ras_err_o = err_q;

  // Stack pointer, occupancy and sticky error register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Push/pop bookkeeping, including overflow and underflow detection
  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push_req) begin
      sp_d = (sp_q == PTR_W'(RAS_DEPTH - 1)) ? '0 : sp_q + PTR_W'(1);
      if (ras_full) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_req) begin
      if (ras_empty) begin
        err_d = 1'b1;
      end else begin
        sp_d  = top_idx;
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // Return-address storage; data only, so it carries no reset
  always_ff @(posedge clk_i) begin
    if (push_req) begin
      ras_mem[sp_q] <= pc_inc;
    end
  end
`else
  logic unused_ras;

  assign ret_sel    = 1'b0;
  assign call_sel   = 1'b0;
  assign pop_addr   = RESET_PC;
  assign ras_err_o  = 1'b0;
  assign unused_ras = ^{call_en_i, ret_en_i, push_req, pop_req, (RAS_DEPTH > 0)};
`endif

endmodule

// File: tb/tb_nrisc_pc_sequencer.sv
// Directed testbench for nrisc_pc_sequencer (default build, plus the
// return-stack sequence when NRISC_RAS_EN is defined).
module tb_nrisc_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       stall;
  logic       branch_en;
  logic [7:0] branch_target;
  logic       jump_en;
  logic [7:0] jump_addr;
  logic       call_en;
  logic       ret_en;
  logic       halt_req;
  logic       resume;
  logic [7:0] pc;
  logic [7:0] pc_plus1;
  logic       fetch_valid;
  logic       flush;
  logic       pc_wrap;
  logic       halted;
  logic       ras_err;

  int checks = 0;
  int errors = 0;

  nrisc_pc_sequencer #(.RESET_PC(8'h00), .RAS_DEPTH(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .stall_i        (stall),
    .branch_en_i    (branch_en),
    .branch_target_i(branch_target),
    .jump_en_i      (jump_en),
    .jump_addr_i    (jump_addr),
    .call_en_i      (call_en),
    .ret_en_i       (ret_en),
    .halt_req_i     (halt_req),
    .resume_i       (resume),
    .pc_o           (pc),
    .pc_plus1_o     (pc_plus1),
    .fetch_valid_o  (fetch_valid),
    .flush_o        (flush),
    .pc_wrap_o      (pc_wrap),
    .halted_o       (halted),
    .ras_err_o      (ras_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks the full observable state for one cycle after inputs settle
  task automatic st(input string tag, input logic [7:0] epc, input logic efv,
                    input logic efl, input logic ewr, input logic eh);
    logic [7:0] ep1;
    #1;
    ep1 = epc + 8'd1;
    chk({tag, ".pc"},       pc,          epc);
    chk({tag, ".pc_plus1"}, pc_plus1,    ep1);
    chk({tag, ".fv"},       fetch_valid, {7'd0, efv});
    chk({tag, ".flush"},    flush,       {7'd0, efl});
    chk({tag, ".wrap"},     pc_wrap,     {7'd0, ewr});
    chk({tag, ".halted"},   halted,      {7'd0, eh});
  endtask

`ifdef NRISC_RAS_EN
  logic [7:0] call_tg [5] = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h80};
  logic [7:0] ret_pc  [4] = '{8'h71, 8'h61, 8'h51, 8'h41};
`endif

  initial begin
    rst = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = 8'h00;
    jump_en = 1'b0; jump_addr = 8'h00; call_en = 1'b0; ret_en = 1'b0;
    halt_req = 1'b0; resume = 1'b0;

    // Reset and boot
    tick(); tick();
    st("rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.ras_err", ras_err, 8'h00);
    rst = 1'b0;
    st("boot", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); st("run00", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); st("run01", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); st("run02", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); st("run03", 8'h03, 1'b1, 1'b0, 1'b0, 1'b0);

    // Jump to 42, then branch to 43
    jump_en = 1'b1; jump_addr = 8'h42;
    tick(); jump_en = 1'b0;
    st("j42_bub", 8'h42, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); st("j42_run", 8'h42, 1'b1, 1'b0, 1'b0, 1'b0);
    branch_en = 1'b1; branch_target = 8'h43;
    tick(); branch_en = 1'b0;
    st("br_bub", 8'h43, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); st("br_run", 8'h43, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); st("br_inc", 8'h44, 1'b1, 1'b0, 1'b0, 1'b0);

    // Wrap FE, FF, 00
    jump_en = 1'b1; jump_addr = 8'hFE;
    tick(); jump_en = 1'b0;
    st("jfe_bub", 8'hFE, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); st("wrap_fe", 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); st("wrap_ff", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); st("wrap_00", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(); st("wrap_01", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall with jump and branch held; jump wins once released
    jump_en = 1'b1; jump_addr = 8'h10;
    tick(); jump_en = 1'b0;
    st("j10_bub", 8'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); st("j10_run", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    stall = 1'b1; jump_en = 1'b1; jump_addr = 8'h80;
    branch_en = 1'b1; branch_target = 8'h55;
    st("stall0", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); st("stall1", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); st("stall2", 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); stall = 1'b0;
    st("unstall", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); jump_en = 1'b0; branch_en = 1'b0;
    st("j80_bub", 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); st("j80_run", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); st("j80_inc", 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

    // Stall during the bubble extends it; flush stays a single pulse
    jump_en = 1'b1; jump_addr = 8'h30;
    tick(); jump_en = 1'b0; stall = 1'b1;
    st("bub_stall", 8'h30, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); stall = 1'b0;
    st("bub_ext", 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); st("run30", 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);

    // Halt at 20 for five cycles, then resume
    jump_en = 1'b1; jump_addr = 8'h20;
    tick(); jump_en = 1'b0;
    st("j20_bub", 8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); st("j20_run", 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    halt_req = 1'b1;
    st("halt_req", 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); halt_req = 1'b0;
    st("halt0", 8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick(); st("halt_hold", 8'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    resume = 1'b1;
    tick(); resume = 1'b0;
    st("resume", 8'h20, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(); st("resume_inc", 8'h21, 1'b1, 1'b0, 1'b0, 1'b0);

    // halt_req wins over stall
    stall = 1'b1; halt_req = 1'b1;
    st("hs_req", 8'h21, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); stall = 1'b0; halt_req = 1'b0;
    st("hs_halt", 8'h21, 1'b0, 1'b0, 1'b0, 1'b1);
    resume = 1'b1;
    tick(); resume = 1'b0;
    st("hs_resume", 8'h21, 1'b1, 1'b0, 1'b0, 1'b0);

    // halt_req during bubble, then reset while halted
    jump_en = 1'b1; jump_addr = 8'h60;
    tick(); jump_en = 1'b0; halt_req = 1'b1;
    st("j60_bub", 8'h60, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); halt_req = 1'b0;
    st("bub_halt", 8'h60, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    tick(); st("rst_halt", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    st("boot2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(); st("run00b", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef NRISC_RAS_EN
    // Call/return round trip
    jump_en = 1'b1; jump_addr = 8'h10;
    tick(); jump_en = 1'b0;
    tick(); st("ras_r10", 8'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    call_en = 1'b1; jump_addr = 8'h80;
    tick(); call_en = 1'b0;
    st("call_bub", 8'h80, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); st("call_run", 8'h80, 1'b1, 1'b0, 1'b0, 1'b0);
    ret_en = 1'b1;
    tick(); ret_en = 1'b0;
    st("ret_bub", 8'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(); st("ret_run", 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("ret.ras_err", ras_err, 8'h00);

    // Five nested calls overflow a four-entry stack
    for (int i = 0; i < 5; i++) begin
      call_en = 1'b1; jump_addr = call_tg[i];
      tick(); call_en = 1'b0;
      st("ncall_bub", call_tg[i], 1'b0, 1'b1, 1'b0, 1'b0);
      chk("ncall.ras_err", ras_err, (i == 4) ? 8'h01 : 8'h00);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      ret_en = 1'b1;
      tick(); ret_en = 1'b0;
      st("nret_bub", ret_pc[i], 1'b0, 1'b1, 1'b0, 1'b0);
      chk("nret.ras_err", ras_err, 8'h01);
      tick();
    end
    ret_en = 1'b1;
    tick(); ret_en = 1'b0;
    st("uflow_bub", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("uflow.ras_err", ras_err, 8'h01);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rst.ras_err_clr", ras_err, 8'h00);
`else
    // Without the stack, call/ret are ignored and the pc increments
    call_en = 1'b1; ret_en = 1'b1; jump_addr = 8'h99;
    tick(); call_en = 1'b0; ret_en = 1'b0;
    st("noras_inc", 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("noras.ras_err", ras_err, 8'h00);
    tick(); st("noras_inc2", 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
